// File: rtl/decoder_stage_controller_if.sv
// ---------------------------------------------------------------------------
// decoder_stage_controller_if
//   Handshake and stage-broadcast bundle between the decode stage controller,
//   the host side (parameter/measurement/result handshakes) and the link/PU
//   array (odd/busy reductions, global stage broadcast).
//
//   Signals
//     param_load    host -> ctrl   request a parameter load
//     meas_valid    host -> ctrl   syndrome available
//     meas_ready    ctrl -> host   syndrome accept strobe
//     any_odd       array -> ctrl  OR of odd-cluster flags
//     any_busy      array -> ctrl  OR of merge-activity flags
//     result_ready  host -> ctrl   consumer accepts the result
//     result_valid  ctrl -> host   result valid
//     global_stage  ctrl -> array  current decode stage
//
//   Modports
//     master : the controller
//     slave  : host/array side (used by a testbench or wrapper)
// ---------------------------------------------------------------------------
interface decoder_stage_controller_if #(
    parameter int STAGE_WIDTH = 3
);
    logic                   param_load;
    logic                   meas_valid;
    logic                   meas_ready;
    logic                   any_odd;
    logic                   any_busy;
    logic                   result_ready;
    logic                   result_valid;
    logic [STAGE_WIDTH-1:0] global_stage;

    modport master (
        input  param_load, meas_valid, any_odd, any_busy, result_ready,
        output meas_ready, result_valid, global_stage
    );

    modport slave (
        output param_load, meas_valid, any_odd, any_busy, result_ready,
        input  meas_ready, result_valid, global_stage
    );
endinterface

// File: rtl/decoder_stage_controller.sv
// ---------------------------------------------------------------------------
// decoder_stage_controller
//   Sequences one decode of the decoder array: parameter load, measurement
//   load, alternating merge/grow rounds until no odd cluster remains (or the
//   round limit is hit), peeling, then the result handshake. The registered
//   FSM state is broadcast as global_stage.
//
//   Ports
//     clk            clock
//     reset          synchronous, active-high reset
//     bus            decoder_stage_controller_if.master (handshakes + stage)
//     round_count    GROW stages executed in the current / last decode
//     params_loaded  parameters loaded since reset
//     round_overflow last decode hit MAX_ROUNDS with any_odd still high
//     merge_timeout  MERGE watchdog fired (optional feature)
//
//   Optional feature
//     STAGE_CTRL_MERGE_TIMEOUT_EN : MERGE watchdog of MERGE_TIMEOUT cycles.
//     When undefined MERGE waits indefinitely and merge_timeout is tied low.
//
//   Stages
//     state    | code | meaning
//     IDLE     |  0   | waiting for param_load or a measurement
//     PARAM    |  1   | weight/boundary shift chain load
//     MEAS     |  2   | syndrome load, links clear growth/error state
//     GROW     |  3   | clusters grow one step
//     MERGE    |  4   | clusters merge, wait for array quiet
//     PEEL     |  5   | peeling decoder, fixed duration
//     RESULT   |  6   | result_valid high until result_ready
//     ILLEGAL  |  7   | unreachable, recovers to IDLE
// ---------------------------------------------------------------------------
module decoder_stage_controller #(
    parameter int STAGE_WIDTH       = 3,
    parameter int PARAM_LOAD_CYCLES = 16,
    parameter int MERGE_MIN_CYCLES  = 2,
    parameter int PEEL_CYCLES       = 8,
    parameter int MAX_ROUNDS        = 15,
    parameter int ROUND_WIDTH       = 4,
    parameter int MERGE_TIMEOUT     = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    decoder_stage_controller_if.master     bus,
    output logic [ROUND_WIDTH-1:0]         round_count,
    output logic                           params_loaded,
    output logic                           round_overflow,
    output logic                           merge_timeout
);

    // A zero minimum dwell still needs one MERGE cycle to sample any_busy.
    localparam int MERGE_MIN_EFF = (MERGE_MIN_CYCLES < 1) ? 1 : MERGE_MIN_CYCLES;

    // One shared down-counter serves every fixed-length stage; it is loaded
    // with (length - 1) on entry and the stage ends when it reads zero.
    localparam int TIMER_MAX_A = (PARAM_LOAD_CYCLES > PEEL_CYCLES) ? PARAM_LOAD_CYCLES : PEEL_CYCLES;
    localparam int TIMER_MAX   = (TIMER_MAX_A > MERGE_MIN_EFF) ? TIMER_MAX_A : MERGE_MIN_EFF;
    localparam int TIMER_WIDTH = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_WIDTH-1:0] PARAM_INIT = TIMER_WIDTH'(PARAM_LOAD_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] PEEL_INIT  = TIMER_WIDTH'(PEEL_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] MERGE_INIT = TIMER_WIDTH'(MERGE_MIN_EFF - 1);
    localparam logic [ROUND_WIDTH-1:0] ROUND_LIMIT = ROUND_WIDTH'(MAX_ROUNDS);

    if (((1 << ROUND_WIDTH) <= MAX_ROUNDS) || (MERGE_TIMEOUT < 1) ||
        (PARAM_LOAD_CYCLES < 1) || (PEEL_CYCLES < 1)) begin : g_bad_params
        $error("decoder_stage_controller: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PARAM   = 3'd1,
        S_MEAS    = 3'd2,
        S_GROW    = 3'd3,
        S_MERGE   = 3'd4,
        S_PEEL    = 3'd5,
        S_RESULT  = 3'd6,
        S_ILLEGAL = 3'd7
    } stage_t;

    stage_t                 state;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   result_valid_q;
    logic                   watchdog_fire;

`ifdef STAGE_CTRL_MERGE_TIMEOUT_EN
    localparam int WD_WIDTH = (MERGE_TIMEOUT > 1) ? $clog2(MERGE_TIMEOUT) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(MERGE_TIMEOUT - 1);

    logic [WD_WIDTH-1:0] wd_count;

    // wd_count is the index of the current MERGE cycle; firing on the last
    // index makes the stage last exactly MERGE_TIMEOUT cycles.
    assign watchdog_fire = (state == S_MERGE) && bus.any_busy && (wd_count == WD_LAST);
`else
    assign watchdog_fire = 1'b0;
    assign merge_timeout = 1'b0;
`endif

    assign bus.global_stage = STAGE_WIDTH'(state);
    assign bus.result_valid = result_valid_q;

    // Accept strobe is combinational so the host sees it in the same cycle
    // the controller commits to MEASUREMENT_LOADING.
    assign bus.meas_ready = (state == S_IDLE) && !bus.param_load &&
                            bus.meas_valid && params_loaded;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            timer          <= '0;
            round_count    <= '0;
            params_loaded  <= 1'b0;
            round_overflow <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef STAGE_CTRL_MERGE_TIMEOUT_EN
            merge_timeout  <= 1'b0;
            wd_count       <= '0;
`endif
        end else begin
`ifdef STAGE_CTRL_MERGE_TIMEOUT_EN
            if (state == S_MERGE) begin
                wd_count <= wd_count + 1'b1;
            end else begin
                wd_count <= '0;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (bus.param_load) begin
                        state <= S_PARAM;
                        timer <= PARAM_INIT;
                    end else if (bus.meas_valid && params_loaded) begin
                        state <= S_MEAS;
                    end
                end

                S_PARAM: begin
                    if (timer == '0) begin
                        state         <= S_IDLE;
                        params_loaded <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_MEAS: begin
                    round_count    <= '0;
                    round_overflow <= 1'b0;
`ifdef STAGE_CTRL_MERGE_TIMEOUT_EN
                    merge_timeout  <= 1'b0;
`endif
                    state          <= S_MERGE;
                    timer          <= MERGE_INIT;
                end

                S_MERGE: begin
                    if (watchdog_fire) begin
`ifdef STAGE_CTRL_MERGE_TIMEOUT_EN
                        merge_timeout <= 1'b1;
`endif
                        state <= S_PEEL;
                        timer <= PEEL_INIT;
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (!bus.any_busy) begin
                        if (!bus.any_odd) begin
                            state <= S_PEEL;
                            timer <= PEEL_INIT;
                        end else if (round_count == ROUND_LIMIT) begin
                            round_overflow <= 1'b1;
                            state          <= S_PEEL;
                            timer          <= PEEL_INIT;
                        end else begin
                            state <= S_GROW;
                        end
                    end
                end

                S_GROW: begin
                    if (round_count != ROUND_LIMIT) begin
                        round_count <= round_count + 1'b1;
                    end
                    state <= S_MERGE;
                    timer <= MERGE_INIT;
                end

                S_PEEL: begin
                    if (timer == '0) begin
                        state          <= S_RESULT;
                        result_valid_q <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_RESULT: begin
                    if (bus.result_ready) begin
                        state          <= S_IDLE;
                        result_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// ---------------------------------------------------------------------------
// tb_decoder_stage_controller
//   Bench for decoder_stage_controller. An array/consumer emulation process
//   drives any_odd/any_busy/result_ready from the broadcast stage and
//   compares each finished decode against the expectation queued at launch.
//   Define STAGE_CTRL_MERGE_TIMEOUT_EN for both bench and RTL to cover the
//   watchdog build.
// ---------------------------------------------------------------------------
module tb_decoder_stage_controller;

    localparam int MAX_ROUNDS = 15;
    localparam int PEEL       = 8;
    localparam int PLOAD      = 16;
    localparam int MERGE_MIN  = 2;
    localparam int WD_LIMIT   = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] round_count;
    logic       params_loaded;
    logic       round_overflow;
    logic       merge_timeout;

    decoder_stage_controller_if #(.STAGE_WIDTH(3)) bus ();

    decoder_stage_controller dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .round_count    (round_count),
        .params_loaded  (params_loaded),
        .round_overflow (round_overflow),
        .merge_timeout  (merge_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rounds;
        int ovf;
        int to;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    // Current decode scenario, read by the array emulation.
    int cur_n_odd = 0;   // number of MERGE exits that see any_odd=1
    int cur_busy  = 0;   // any_busy high for the first cur_busy MERGE cycles
    int cur_to    = 0;   // this decode is expected to end by watchdog
    int done_cnt  = 0;

    // Emulation/monitor state
    int grows = 0;
    int peels = 0;
    int mcyc  = 0;
    int prev_st = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Array emulation + result monitor, all on the falling edge.
    always @(negedge clk) begin : monitor
        int   st;
        int   exp_len;
        bit   rr;
        exp_t e;
        if (reset) begin
            grows = 0; peels = 0; mcyc = 0; prev_st = 0;
            bus.any_busy     = 1'b0;
            bus.any_odd      = 1'b0;
            bus.result_ready = 1'b0;
        end else begin
            st = int'(bus.global_stage);
            if (prev_st == 4 && st != 4) begin
                exp_len = cur_to ? WD_LIMIT : ((cur_busy + 1 > MERGE_MIN) ? cur_busy + 1 : MERGE_MIN);
                check("merge_len", mcyc, exp_len);
                mcyc = 0;
            end
            if (st == 3) grows++;
            if (st == 5) peels++;
            if (st == 4) begin
                bus.any_busy = (mcyc < cur_busy);
                mcyc++;
            end else begin
                bus.any_busy = 1'b0;
            end
            bus.any_odd = (grows < cur_n_odd);
            check("result_valid_vs_stage", int'(bus.result_valid), int'(st == 6));
            rr = ($urandom_range(0, 2) == 0);
            bus.result_ready = rr;
            if (st == 6 && rr) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("round_count", int'(round_count), e.rounds);
                    check("grow_cycles", grows, e.rounds);
                    check("round_overflow", int'(round_overflow), e.ovf);
                    check("merge_timeout", int'(merge_timeout), e.to);
                    check("peel_cycles", peels, PEEL);
                end
                grows = 0;
                peels = 0;
                done_cnt++;
            end
            prev_st = st;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.param_load = 1'b0;
        bus.meas_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic param_load(input bit with_meas);
        int cnt;
        @(negedge clk);
        bus.param_load = 1'b1;
        bus.meas_valid = with_meas;
        #1;
        check("meas_ready_during_param_load", int'(bus.meas_ready), 0);
        cnt = 0;
        @(negedge clk);
        while (int'(bus.global_stage) == 1 && cnt < 100) begin
            cnt++;
            bus.param_load = 1'b0;
            bus.meas_valid = 1'b0;
            @(negedge clk);
        end
        bus.param_load = 1'b0;
        bus.meas_valid = 1'b0;
        check("param_load_cycles", cnt, PLOAD);
        check("stage_after_param_load", int'(bus.global_stage), 0);
        check("params_loaded", int'(params_loaded), 1);
    endtask

    task automatic launch(input int n_odd, input int busy, input int to);
        exp_t e;
        int   k;
        k = 0;
        while (int'(bus.global_stage) != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_launch", int'(bus.global_stage), 0);
        cur_n_odd = n_odd;
        cur_busy  = busy;
        cur_to    = to;
        e.rounds  = (n_odd > MAX_ROUNDS) ? MAX_ROUNDS : n_odd;
        e.ovf     = (n_odd > MAX_ROUNDS) ? 1 : 0;
        e.to      = to;
        q.push_back(e);
        bus.meas_valid = 1'b1;
        #1;
        check("meas_ready_strobe", int'(bus.meas_ready), 1);
        @(negedge clk);
        bus.meas_valid = 1'b0;
        check("meas_loading_stage", int'(bus.global_stage), 2);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("decode_completed", int'(done_cnt != d0), 1);
    endtask

    initial begin : stim
        int n;
        int k;
        bus.param_load = 1'b0;
        bus.meas_valid = 1'b0;
        apply_reset();

        check("rst_stage", int'(bus.global_stage), 0);
        check("rst_round_count", int'(round_count), 0);
        check("rst_params_loaded", int'(params_loaded), 0);
        check("rst_round_overflow", int'(round_overflow), 0);
        check("rst_merge_timeout", int'(merge_timeout), 0);
        check("rst_result_valid", int'(bus.result_valid), 0);

        // Measurement without parameters is ignored.
        bus.meas_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("meas_ready_no_params", int'(bus.meas_ready), 0);
            @(negedge clk);
            check("stage_no_params", int'(bus.global_stage), 0);
        end
        bus.meas_valid = 1'b0;

        param_load(1'b0);

        // Directed decodes: clean, three rounds, stuck odd.
        launch(0, 0, 0);
        wait_done(3000);
        launch(3, 1, 0);
        wait_done(3000);
        launch(40, 0, 0);
        wait_done(3000);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: n = 0;
                1: n = $urandom_range(1, 5);
                2: n = $urandom_range(13, 17);
                default: n = 30;
            endcase
            launch(n, $urandom_range(0, 4), 0);
            wait_done(3000);
        end

        // Reset during the fifth MERGE round.
        launch(20, 1, 0);
        k = 0;
        while (!(grows == 5 && int'(bus.global_stage) == 4) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reached_round5_merge", int'(grows == 5 && int'(bus.global_stage) == 4), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_stage", int'(bus.global_stage), 0);
        check("midrst_params_loaded", int'(params_loaded), 0);
        check("midrst_round_count", int'(round_count), 0);
        check("midrst_result_valid", int'(bus.result_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();

        // Reload with meas_valid also high: param_load must win.
        param_load(1'b1);

        // any_busy stuck high.
        launch(0, 1000000, `ifdef STAGE_CTRL_MERGE_TIMEOUT_EN 1 `else 0 `endif);
`ifdef STAGE_CTRL_MERGE_TIMEOUT_EN
        wait_done(3000);
`else
        repeat (1000) @(negedge clk);
        check("stuck_busy_stays_merge", int'(bus.global_stage), 4);
        check("stuck_busy_no_timeout", int'(merge_timeout), 0);
        apply_reset();
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_bound
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
